ibex_csr_bank: RTL and testbench
================================

# ibex_csr_bank

Parametrised bank of NumRegs control/status registers with per-register write masks, write/set/clear operations, per-register lock, and optional inverted shadow copies. A background scrub sequencer continuously cross-checks every register against its shadow and raises a sticky alert. It sits behind the CSR file's decode logic and replaces groups of individual single-register CSR primitives where a set of related CSRs, such as PMP configuration or custom control registers, needs hardened storage.

## Interface
- NumRegs, 4: number of registers in the bank (≥1).
- Width, 32: bits per register.
- ShadowCopy, 1'b1: instantiate an inverted shadow per register, plus the scrubber.
- ResetValue, '0: packed [NumRegs-1:0][Width-1:0] reset value per register.
- WriteMask, all ones: packed [NumRegs-1:0][Width-1:0]; 0 bits are read-only and hold their reset value.
- IdxW, derived: NumRegs>1 ? $clog2(NumRegs) : 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- wr_en_i  in  1  write request this cycle.
- wr_op_i  in  2  0 = write, 1 = set (OR), 2 = clear (AND-NOT), 3 = illegal.
- wr_idx_i  in  IdxW  target register for writes.
- wr_data_i  in  Width  write operand.
- lock_i  in  NumRegs  per-register lock; a locked register ignores writes.
- rd_idx_i  in  IdxW  read select.
- rd_data_o  out  Width  current value of register rd_idx_i.
- rd_error_o  out  1  shadow mismatch on register rd_idx_i (combinational).
- regs_o  out  NumRegs*Width  all register values, flat, for hardwired consumers.
- wr_reject_o  out  1  registered pulse: last write was dropped (locked, illegal op, or idx ≥ NumRegs).
- scrub_en_i  in  1  enable the background scrubber.
- alert_o  out  1  sticky integrity alert.
- alert_idx_o  out  IdxW  index of the first register that raised alert_o.

## Operation
- Write value: base = wr_data_i (op 0), old | wr_data_i (op 1), old & ~wr_data_i (op 2). Stored value = (old & ~WriteMask[i]) | (base & WriteMask[i]). Shadow stores ~stored in the same edge.
- The write is dropped when lock_i[wr_idx_i] = 1, wr_op_i = 3, or wr_idx_i ≥ NumRegs. A dropped write leaves both copies unchanged and sets wr_reject_o high for one cycle.
- Reads are combinational from the primary copy. rd_idx_i ≥ NumRegs returns 0, with rd_error_o = 0.
- rd_error_o = primary != ~shadow for the selected register. It is 0 when ShadowCopy = 0.
- Scrubber FSM has two states, IDLE and SCAN, with a scan counter scan_q of IdxW bits.
  - IDLE→SCAN when scrub_en_i = 1.
  - SCAN→IDLE when scrub_en_i = 0; scan_q holds its value.
  - In SCAN, each cycle checks register scan_q, then increments scan_q, wrapping from NumRegs-1 to 0.
  - When ShadowCopy = 0 the FSM stays in IDLE.
- alert_o is set by either of two mismatches: the scrubber finding a mismatch, or rd_error_o = 1 while a read is in progress.
  - A read counts as in progress for every cycle, because rd_idx_i is always sampled.
  - alert_o is cleared only by reset.
- alert_idx_o captures the failing index on the first set of alert_o, then freezes.
- If the read check and the scrubber fail in the same cycle, the scrubber index takes priority.

## Timing
- Reset values:
  - registers = ResetValue; shadows = ~ResetValue.
  - rd_error_o = 0; alert_o = 0; alert_idx_o = 0; wr_reject_o = 0.
  - FSM = IDLE; scan_q = 0.
- Write latency: the value is visible on rd_data_o/regs_o the cycle after the wr_en_i edge.
- A scrub check of the register being written in the same cycle sees the pre-write copies, which are consistent, so no false alert.
- alert_o rises one cycle after the mismatching check cycle.
- A full scan pass takes NumRegs cycles of scrub_en_i = 1.
- Asserting rst_ni low mid-scan returns everything to reset values immediately, asynchronously.
- wr_en_i must never be X (assertion).

## Test plan
- Reset, then read each register → ResetValue[i]; alert_o = 0, wr_reject_o = 0.
- WriteMask[1] = 32'h0000_00FF, ResetValue[1] = 32'hA5A5_0000:
  - write 32'hFFFF_FFFF to idx 1 → 32'hA5A5_00FF.
  - then clear 32'h0000_000F → 32'hA5A5_00F0.
  - then set 32'h0000_0001 → 32'hA5A5_00F1.
- lock_i[2] = 1, write 32'h1234 to idx 2 → value unchanged; wr_reject_o = 1 for exactly one cycle. Same result for wr_op_i = 3 and for wr_idx_i = NumRegs (when NumRegs is not a power of 2).
- Force the shadow of register 3 to a corrupt value, with scrub_en_i = 1 and rd_idx_i = 0 → alert_o rises within NumRegs+1 cycles; alert_idx_o = 3; alert_o stays high after scrub_en_i drops.
- With scrub_en_i = 1, write to the register under scan each cycle for 2×NumRegs cycles → alert_o stays 0; scan_q wraps NumRegs-1→0.
- Assert rst_ni low mid-scan with alert_o = 1 → alert_o, alert_idx_o and scan_q are 0 immediately, and registers are back to ResetValue.

Source files
------------

// File: rtl/ibex_csr_bank.sv
// Hardened CSR bank: masked write/set/clear with per-register lock, optional inverted shadows and a background scrubber.
// Writes are visible the cycle after the edge; reads and rd_error_o are combinational; alert_o is sticky until reset.
module ibex_csr_bank #(
    parameter int unsigned                     NumRegs    = 4,
    parameter int unsigned                     Width      = 32,
    parameter bit                              ShadowCopy = 1'b1,
    parameter logic [NumRegs-1:0][Width-1:0]   ResetValue = '0,
    parameter logic [NumRegs-1:0][Width-1:0]   WriteMask  = '1,
    localparam int unsigned                    IdxW       = (NumRegs > 1) ? $clog2(NumRegs) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_en_i,
    input  logic [1:0]                 wr_op_i,
    input  logic [IdxW-1:0]            wr_idx_i,
    input  logic [Width-1:0]           wr_data_i,
    input  logic [NumRegs-1:0]         lock_i,
    input  logic [IdxW-1:0]            rd_idx_i,
    output logic [Width-1:0]           rd_data_o,
    output logic                       rd_error_o,
    output logic [NumRegs*Width-1:0]   regs_o,
    output logic                       wr_reject_o,
    input  logic                       scrub_en_i,
    output logic                       alert_o,
    output logic [IdxW-1:0]            alert_idx_o
);

    typedef enum logic {IDLE, SCAN} scrub_state_e;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRegs - 1);

    logic [NumRegs-1:0][Width-1:0] regs_q;
    logic [NumRegs-1:0][Width-1:0] wr_val;
    logic [NumRegs-1:0]            wr_hit;
    logic [NumRegs-1:0]            mismatch;
    logic [Width-1:0]              base;
    logic                          wr_idx_ok;
    logic                          wr_locked;
    logic                          wr_drop;
    logic                          wr_reject_q;
    scrub_state_e                  state_q;
    logic [IdxW-1:0]               scan_q;
    logic [IdxW-1:0]               alert_idx_q;
    logic                          alert_q;
    logic                          scan_fail;

    // Every register computes its own candidate value; only the addressed one is committed.
    always_comb begin
        base      = '0;
        wr_idx_ok = 1'b0;
        wr_locked = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (wr_idx_i == IdxW'(i)) begin
                wr_idx_ok = 1'b1;
                wr_locked = lock_i[i];
            end
            case (wr_op_i)
                2'd1:    base = regs_q[i] | wr_data_i;
                2'd2:    base = regs_q[i] & ~wr_data_i;
                default: base = wr_data_i;
            endcase
            wr_val[i] = (regs_q[i] & ~WriteMask[i]) | (base & WriteMask[i]);
        end
        wr_drop = wr_locked || (wr_op_i == 2'd3) || !wr_idx_ok;
        for (int i = 0; i < NumRegs; i++) begin
            wr_hit[i] = wr_en_i && !wr_drop && (wr_idx_i == IdxW'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q      <= ResetValue;
            wr_reject_q <= 1'b0;
        end else begin
            for (int i = 0; i < NumRegs; i++) begin
                if (wr_hit[i]) regs_q[i] <= wr_val[i];
            end
            wr_reject_q <= wr_en_i && wr_drop;
        end
    end

    if (ShadowCopy) begin : g_shadow
        logic [NumRegs-1:0][Width-1:0] shadow_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                shadow_q <= ~ResetValue;
            end else begin
                for (int i = 0; i < NumRegs; i++) begin
                    if (wr_hit[i]) shadow_q[i] <= ~wr_val[i];
                end
            end
        end

        always_comb begin
            for (int i = 0; i < NumRegs; i++) begin
                mismatch[i] = regs_q[i] != ~shadow_q[i];
            end
        end
    end else begin : g_no_shadow
        assign mismatch = '0;
    end

    always_comb begin
        rd_data_o  = '0;
        rd_error_o = 1'b0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rd_idx_i == IdxW'(i)) begin
                rd_data_o  = regs_q[i];
                rd_error_o = mismatch[i];
            end
        end
    end

    // A check of a register being written this cycle sees the consistent pre-write pair.
    assign scan_fail = (state_q == SCAN) && scrub_en_i && mismatch[scan_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            scan_q      <= '0;
            alert_q     <= 1'b0;
            alert_idx_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (scrub_en_i && ShadowCopy) state_q <= SCAN;
                SCAN: begin
                    if (!scrub_en_i) state_q <= IDLE;
                    else             scan_q  <= (scan_q == LastIdx) ? '0 : scan_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
            if (!alert_q && (scan_fail || rd_error_o)) begin
                alert_q     <= 1'b1;
                alert_idx_q <= scan_fail ? scan_q : rd_idx_i;
            end
        end
    end

    assign regs_o      = regs_q;
    assign wr_reject_o = wr_reject_q;
    assign alert_o     = alert_q;
    assign alert_idx_o = alert_idx_q;

    wr_en_known_a: assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(wr_en_i));

endmodule

// File: tb/tb_ibex_csr_bank.sv
// Bench for ibex_csr_bank: reset/table vectors, randomized traffic against an array model, scrub and alert sequences.
module tb_ibex_csr_bank;

    localparam int NR = 5;
    localparam int W  = 32;
    localparam logic [NR-1:0][W-1:0] RV = {32'h4444_4444, 32'h1111_2222, 32'hDEAD_BEEF,
                                           32'hA5A5_0000, 32'h0000_0001};
    localparam logic [NR-1:0][W-1:0] WM = {32'hFFFF_FFFF, 32'hFFFF_0FFF, 32'hFFFF_FFFF,
                                           32'h0000_00FF, 32'hFFFF_FFFF};

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              wr_en = 1'b0;
    logic [1:0]        wr_op = '0;
    logic [2:0]        wr_idx = '0;
    logic [W-1:0]      wr_data = '0;
    logic [NR-1:0]     lock = '0;
    logic [2:0]        rd_idx = '0;
    logic              scrub_en = 1'b0;
    logic [W-1:0]      rd_data;
    logic              rd_error;
    logic [NR*W-1:0]   regs;
    logic              wr_reject;
    logic              alert;
    logic [2:0]        alert_idx;

    ibex_csr_bank #(
        .NumRegs(NR), .Width(W), .ShadowCopy(1'b1), .ResetValue(RV), .WriteMask(WM)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en), .wr_op_i(wr_op), .wr_idx_i(wr_idx),
        .wr_data_i(wr_data), .lock_i(lock), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .rd_error_o(rd_error), .regs_o(regs), .wr_reject_o(wr_reject), .scrub_en_i(scrub_en),
        .alert_o(alert), .alert_idx_o(alert_idx)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    // Reference model: register array plus scan position, advanced once per clock edge.
    logic [W-1:0] m_regs [NR];
    bit           m_scanning;
    int           m_pos;
    logic         m_rej;
    logic [NR-1:0][W-1:0] sh;

    typedef struct {
        logic [1:0]    op;
        logic [2:0]    widx;
        logic [W-1:0]  data;
        logic [NR-1:0] lk;
        logic [2:0]    ridx;
        logic [W-1:0]  exp_rd;
        logic          exp_rej;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [NR*W-1:0] act, input logic [NR*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < NR; i++) m_regs[i] = RV[i];
        m_scanning = 1'b0;
        m_pos      = 0;
        m_rej      = 1'b0;
    endtask

    task automatic model_edge();
        logic [W-1:0] b;
        logic         rej;
        int           k;
        k   = int'(wr_idx);
        rej = 1'b0;
        if (wr_en) begin
            if (wr_op == 2'd3 || k >= NR) rej = 1'b1;
            else if (lock[k]) rej = 1'b1;
            else begin
                if (wr_op == 2'd1)      b = m_regs[k] | wr_data;
                else if (wr_op == 2'd2) b = m_regs[k] & ~wr_data;
                else                    b = wr_data;
                m_regs[k] = (m_regs[k] & ~WM[k]) | (b & WM[k]);
            end
        end
        m_rej = rej;
        if (m_scanning && scrub_en) m_pos = (m_pos + 1) % NR;
        m_scanning = scrub_en;
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge();
        #1;
    endtask

    function automatic logic [NR*W-1:0] model_flat();
        logic [NR*W-1:0] f;
        for (int i = 0; i < NR; i++) f[i*W +: W] = m_regs[i];
        return f;
    endfunction

    task automatic check_all();
        int r;
        r = int'(rd_idx);
        chk("rd_data", rd_data, (r < NR) ? m_regs[r] : '0);
        chk("rd_error", rd_error, 0);
        chk("wr_reject", wr_reject, m_rej);
        chk("alert", alert, 0);
        chk("scan_q", dut.scan_q, m_pos);
        chk("regs_o", regs, model_flat());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{2'd0, 3'd1, 32'hFFFF_FFFF, 5'b00000, 3'd1, 32'hA5A5_00FF, 1'b0};
        vecs[1]  = '{2'd2, 3'd1, 32'h0000_000F, 5'b00000, 3'd1, 32'hA5A5_00F0, 1'b0};
        vecs[2]  = '{2'd1, 3'd1, 32'h0000_0001, 5'b00000, 3'd1, 32'hA5A5_00F1, 1'b0};
        vecs[3]  = '{2'd0, 3'd2, 32'h0000_1234, 5'b00100, 3'd2, 32'hDEAD_BEEF, 1'b1};
        vecs[4]  = '{2'd3, 3'd2, 32'h0000_1234, 5'b00000, 3'd2, 32'hDEAD_BEEF, 1'b1};
        vecs[5]  = '{2'd0, 3'd5, 32'h0000_1234, 5'b00000, 3'd5, 32'h0000_0000, 1'b1};
        vecs[6]  = '{2'd0, 3'd7, 32'h0000_1234, 5'b00000, 3'd2, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{2'd0, 3'd0, 32'hCAFE_0000, 5'b00100, 3'd0, 32'hCAFE_0000, 1'b0};
        vecs[8]  = '{2'd0, 3'd2, 32'h0000_1234, 5'b00000, 3'd2, 32'h0000_1234, 1'b0};
        vecs[9]  = '{2'd0, 3'd3, 32'hFFFF_FFFF, 5'b00000, 3'd3, 32'hFFFF_2FFF, 1'b0};
        vecs[10] = '{2'd2, 3'd3, 32'hFFFF_FFFF, 5'b00000, 3'd3, 32'h0000_2000, 1'b0};
        vecs[11] = '{2'd1, 3'd4, 32'h00F0_000F, 5'b10000, 3'd4, 32'h4444_4444, 1'b1};

        // Reset state
        reset_model();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        chk("rst_alert", alert, 0);
        chk("rst_alert_idx", alert_idx, 0);
        chk("rst_wr_reject", wr_reject, 0);
        chk("rst_scan_q", dut.scan_q, 0);
        chk("rst_regs_o", regs, RV);
        for (int i = 0; i < NR + 1; i++) begin
            rd_idx = 3'(i);
            #1;
            chk("rst_rd_data", rd_data, (i < NR) ? RV[i] : '0);
            chk("rst_rd_error", rd_error, 0);
        end

        // Directed vector table
        for (int v = 0; v < 12; v++) begin
            wr_en = 1'b1; wr_op = vecs[v].op; wr_idx = vecs[v].widx;
            wr_data = vecs[v].data; lock = vecs[v].lk; rd_idx = vecs[v].ridx;
            step();
            chk($sformatf("vec%0d_rd", v), rd_data, vecs[v].exp_rd);
            chk($sformatf("vec%0d_rej", v), wr_reject, vecs[v].exp_rej);
            wr_en = 1'b0; lock = '0;
            step();
            chk($sformatf("vec%0d_rej_pulse", v), wr_reject, 0);
            chk($sformatf("vec%0d_hold", v), rd_data, vecs[v].exp_rd);
        end

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            wr_en   = ($urandom_range(0, 2) != 0);
            wr_op   = 2'($urandom_range(0, 3));
            wr_idx  = 3'($urandom_range(0, 7));
            wr_data = $urandom;
            lock    = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
            rd_idx  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) scrub_en = ~scrub_en;
            step();
            check_all();
        end

        // Write the register under scan every cycle: no false alert, scan_q wraps
        scrub_en = 1'b1; lock = '0;
        for (int c = 0; c < 2 * NR + 1; c++) begin
            wr_en   = 1'b1;
            wr_op   = 2'($urandom_range(0, 2));
            wr_idx  = 3'(m_pos);
            wr_data = $urandom;
            rd_idx  = 3'(m_pos);
            step();
            check_all();
        end

        // Corrupt shadow of register 3, scrubber must flag it
        wr_en = 1'b0; rd_idx = 3'd0;
        for (int i = 0; i < NR; i++) sh[i] = ~m_regs[i];
        sh[3] = sh[3] ^ 32'h0000_0100;
        force dut.g_shadow.shadow_q = sh;
        for (int c = 0; c < NR + 1; c++) begin
            if (alert) break;
            step();
        end
        chk("scrub_alert", alert, 1);
        chk("scrub_alert_idx", alert_idx, 3);
        rd_idx = 3'd3;
        #1 chk("rd_error_corrupt", rd_error, 1);
        scrub_en = 1'b0; rd_idx = 3'd0;
        repeat (3) step();
        chk("alert_sticky", alert, 1);
        chk("alert_idx_frozen", alert_idx, 3);

        // Asynchronous reset in the middle of a scan
        scrub_en = 1'b1;
        repeat (3) step();
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_alert", alert, 0);
        chk("arst_alert_idx", alert_idx, 0);
        chk("arst_scan_q", dut.scan_q, 0);
        chk("arst_regs_o", regs, RV);
        chk("arst_wr_reject", wr_reject, 0);
        release dut.g_shadow.shadow_q;
        scrub_en = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        reset_model();
        for (int i = 0; i < NR; i++) begin
            rd_idx = 3'(i);
            #1;
            chk("post_rst_rd_error", rd_error, 0);
            chk("post_rst_rd_data", rd_data, RV[i]);
        end

        // Read-path mismatch alone raises the alert with the read index
        for (int i = 0; i < NR; i++) sh[i] = ~m_regs[i];
        sh[2] = sh[2] ^ 32'h8000_0000;
        force dut.g_shadow.shadow_q = sh;
        rd_idx = 3'd2;
        #1;
        chk("rd_err_path", rd_error, 1);
        chk("rd_alert_before_edge", alert, 0);
        step();
        chk("rd_alert", alert, 1);
        chk("rd_alert_idx", alert_idx, 2);
        release dut.g_shadow.shadow_q;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
